serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial adder wrapped around a single one-bit full-adder cell
//   (a, b, c -> s, cy).
//   - Accepts two WIDTH-bit operands and a carry-in on a start pulse.
//   - Feeds the cell one bit pair per clock, LSB first, with a registered carry.
//   - Assembles the WIDTH-bit sum and carry-out, then pulses done.
//   - Sits directly upstream of the full-adder cell and consumes its s/cy
//     outputs. Gives the combinational adder a sequential, handshaked
//     multi-bit front end.
//
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (>= 2)
//
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      request: load a_in/b_in/cin, begin addition
//   a_in    in   WIDTH  operand A (sampled only when start accepted)
//   b_in    in   WIDTH  operand B (sampled only when start accepted)
//   cin     in   1      carry-in (sampled only when start accepted)
//   busy    out  1      high while bits are being shifted (SHIFT state)
//   done    out  1      one-cycle pulse: sum/cout valid
//   sum     out  WIDTH  result, held until next completion
//   cout    out  1      carry-out, held until next completion
//
// BEHAVIOUR
//   Reset:
//     - rst sampled high at a rising edge -> state=IDLE; busy=0, done=0,
//       sum=0, cout=0; shift registers, carry and bit counter cleared.
//     - rst mid-operation aborts the addition; no done pulse is generated.
//
//   State machine: IDLE -> SHIFT -> DONE -> IDLE
//     IDLE:
//       - start=1 -> load a_sr=a_in, b_sr=b_in, carry=cin, cnt=0.
//       - Go to SHIFT.
//     SHIFT (busy=1), each cycle:
//       - {cy,s} = a_sr[0] + b_sr[0] + carry.
//       - a_sr, b_sr shift right by one.
//       - s_sr shifts right with s inserted at MSB.
//       - carry <= cy; cnt++.
//       - When cnt==WIDTH-1 on this cycle -> sum <= final s_sr, cout <= cy,
//         go to DONE.
//     DONE (done=1, busy=0), exactly one cycle:
//       - start=1 -> accept immediately (load as in IDLE), go to SHIFT
//         (back-to-back).
//       - Otherwise go to IDLE.
//
//   Latency:
//     - start sampled at edge E -> busy high after E for WIDTH cycles.
//     - done high during the cycle following edge E+WIDTH.
//     - Minimum issue interval: WIDTH+1 cycles.
//
//   Handshake and output rules:
//     - start is ignored while busy=1; operands changing during SHIFT have
//       no effect.
//     - sum/cout update only on the edge entering DONE. They are not cleared
//       by start.
//     - Arithmetic is unsigned modulo 2^WIDTH with separate carry-out:
//       {cout,sum} = a_in + b_in + cin (WIDTH+1 bits, no overflow lost).
//     - cnt is wide enough for WIDTH-1 ($clog2(WIDTH)); no wrap inside one
//       operation.
//
// TESTING (WIDTH=8)
//   1. 00+00, cin=0, start 1 cycle -> busy 8 cycles; done pulse at E+9;
//      sum=00, cout=0.
//   2. FF+01, cin=0 -> sum=00, cout=1; A5+5A, cin=1 -> sum=00, cout=1;
//      7F+01, cin=0 -> sum=80, cout=0.
//   3. start held high, a_in/b_in toggled during SHIFT -> result matches
//      first loaded operands; exactly one done per accepted start.
//   4. start=1 in the DONE cycle with 12+34 -> no IDLE cycle; next done
//      WIDTH+1 cycles later; sum=46, cout=0.
//   5. rst asserted at cycle 4 of SHIFT -> next cycle busy=0, sum=00,
//      cout=0; no done pulse.
//   6. Random sweep of 1000 operand/cin triples vs {cout,sum}=a+b+cin
//      reference model -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller around a one-bit full-adder
// cell. Operands are loaded on an accepted start, fed to the cell LSB first
// with a registered carry, and the assembled sum/carry-out are published with
// a one-cycle done pulse.

// One-bit full-adder cell consumed by the serial controller.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic cy_o
);

    // Pure combinational sum and carry of three input bits.
    always_comb begin
        s_o  = a_i ^ b_i ^ c_i;
        cy_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_s;
    logic               fa_cy;
    logic               accept;
    logic               last_bit;

    // The cell always sees the current LSBs and the registered carry.
    full_adder_cell u_cell (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .cy_o (fa_cy)
    );

    // Start is honoured in IDLE and in the DONE cycle (back-to-back issue).
    always_comb begin
        accept   = start && (state_q != SHIFT);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE/SHIFT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per SHIFT cycle.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_sr_d  = a_in;
            b_sr_d  = b_in;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
            carry_d = fa_cy;
            cnt_d   = cnt_q + CNT_W'(1);
            // Publish including the bit produced on this final cycle.
            if (last_bit) begin
                sum_d  = s_sr_d;
                cout_d = fa_cy;
            end
        end
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Outputs decoded from state and held result registers.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed scenarios
// followed by a random sweep against an arithmetic reference.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int unsigned  vectors     = 0;
    int unsigned  miscompares = 0;

    // Last published result expected on sum/cout.
    logic [W-1:0] ref_sum  = '0;
    logic         ref_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one addition from a negedge; returns at the negedge inside DONE.
    task automatic add_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit hold, input bit scramble);
        logic [W:0] expv;
        expv  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < W; i++) begin
            check("busy_high", 32'(busy), 32'd1);
            check("done_low", 32'(done), 32'd0);
            check("sum_held", 32'(sum), 32'(ref_sum));
            check("cout_held", 32'(cout), 32'(ref_cout));
            start = hold && (i < W - 1);
            if (scramble) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                cin  = 1'($urandom);
            end
            @(negedge clk);
        end
        ref_sum  = expv[W-1:0];
        ref_cout = expv[W];
        check("done_pulse", 32'(done), 32'd1);
        check("busy_low", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(ref_sum));
        check("cout", 32'(cout), 32'(ref_cout));
    endtask

    // One cycle after DONE with no new start: back in IDLE.
    task automatic idle_check();
        start = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sum", 32'(sum), 32'(ref_sum));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero operands, basic latency.
        add_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_check();

        // Carry boundaries.
        add_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_check();
        add_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle_check();
        add_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_check();

        // Start held and operands disturbed during SHIFT.
        add_op(8'h3C, 8'hD9, 1'b1, 1'b1, 1'b1);
        idle_check();

        // Back-to-back issue from the DONE cycle.
        add_op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        add_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        check("b2b_sum", 32'(sum), 32'h46);
        idle_check();

        // Reset during SHIFT aborts with no done pulse.
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ref_sum  = '0;
        ref_cout = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        for (int unsigned i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end

        // Random sweep, mixing idle gaps and back-to-back issue.
        for (int unsigned n = 0; n < 1000; n++) begin
            add_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
